// File: rtl/onehot_ring_decoder.sv
// Decoder for a 4-bit one-hot ring counter (1->2->4->8->1): step index, advance/lap pulses,
// lap counter and sticky fault. Define LAP_SATURATE_EN to make the lap counter saturate instead of wrap.
module onehot_ring_decoder #(
    parameter int LAP_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [3:0]       code,
    output logic [1:0]       index,
    output logic             valid,
    output logic             step,
    output logic             lap,
    output logic [LAP_W-1:0] laps,
    output logic             fault,
    output logic [3:0]       bad_code
);

    // state | meaning
    // IDLE  | upstream held at 0, waiting for code 1 to start a lap
    // TRACK | locked to the ring, prev is the last accepted code
    // FAULT | illegal code or transition seen, waiting for clear
    typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_t;

    state_t     state;
    logic [3:0] prev;
    logic [LAP_W-1:0] laps_inc;

    function automatic logic [3:0] next_code(input logic [3:0] c);
        case (c)
            4'd1:    next_code = 4'd2;
            4'd2:    next_code = 4'd4;
            4'd4:    next_code = 4'd8;
            4'd8:    next_code = 4'd1;
            default: next_code = 4'd0;
        endcase
    endfunction

    function automatic logic [1:0] code_index(input logic [3:0] c);
        case (c)
            4'd2:    code_index = 2'd1;
            4'd4:    code_index = 2'd2;
            4'd8:    code_index = 2'd3;
            default: code_index = 2'd0;
        endcase
    endfunction

`ifdef LAP_SATURATE_EN
    assign laps_inc = (laps == {LAP_W{1'b1}}) ? laps : laps + LAP_W'(1);
`else
    assign laps_inc = laps + LAP_W'(1);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            prev     <= 4'd0;
            index    <= 2'd0;
            valid    <= 1'b0;
            step     <= 1'b0;
            lap      <= 1'b0;
            laps     <= '0;
            fault    <= 1'b0;
            bad_code <= 4'd0;
        end else begin
            step <= 1'b0;
            lap  <= 1'b0;
            case (state)
                IDLE: begin
                    if (code == 4'd1) begin
                        state <= TRACK;
                        index <= 2'd0;
                        valid <= 1'b1;
                        step  <= 1'b1;
                        prev  <= code;
                    end else if (code != 4'd0) begin
                        state    <= FAULT;
                        fault    <= 1'b1;
                        bad_code <= code;
                    end
                end
                TRACK: begin
                    if (code == prev) begin
                        state <= TRACK;
                    end else if (code == 4'd0) begin
                        // upstream was reset; lap count survives
                        state <= IDLE;
                        valid <= 1'b0;
                        index <= 2'd0;
                        prev  <= 4'd0;
                    end else if (code == next_code(prev)) begin
                        index <= code_index(code);
                        step  <= 1'b1;
                        prev  <= code;
                        if (prev == 4'd8) begin
                            lap  <= 1'b1;
                            laps <= laps_inc;
                        end
                    end else begin
                        state    <= FAULT;
                        fault    <= 1'b1;
                        bad_code <= code;
                        valid    <= 1'b0;
                    end
                end
                FAULT: begin
                    if (clear) begin
                        state    <= IDLE;
                        fault    <= 1'b0;
                        bad_code <= 4'd0;
                        prev     <= 4'd0;
                        index    <= 2'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/onehot_ring_decoder.md
# onehot_ring_decoder

Receive-side decoder for the 4-bit one-hot ring counter sequence (0 → 1 → 2 → 4 → 8 → 1 …). It samples the ring value every clock and converts it to a binary step index. It also emits one-cycle pulses on each advance and each completed lap, counts laps, and flags any illegal code or out-of-order transition with a sticky fault. It sits directly downstream of the ring counter output and feeds status/display logic.

## Interface
- LAP_W, 8, width of the lap counter
- clk  input  1  rising-edge clock
- reset  input  1  reset, synchronous, active-high
- clear  input  1  synchronous fault clear; leaves FAULT for IDLE
- code  input  4  ring value from the upstream counter
- index  output  2  binary step index: 1→0, 2→1, 4→2, 8→3
- valid  output  1  high while in TRACK
- step  output  1  one-cycle pulse on each legal advance, including entry from IDLE
- lap  output  1  one-cycle pulse on each 8→1 transition
- laps  output  LAP_W  completed-lap count
- fault  output  1  sticky error flag; high in FAULT
- bad_code  output  4  code value that caused the fault

## Operation
- States: IDLE, TRACK, FAULT. `prev` holds the last accepted code.
- Legal successor relation: next(1)=2, next(2)=4, next(4)=8, next(8)=1.
- Reset values: state=IDLE, index=0, valid=0, step=0, lap=0, laps=0, fault=0, bad_code=0, prev=0.
- IDLE:
  - code=0: stay.
  - code=1: go to TRACK; index=0, valid=1, step=1, prev=1.
  - Any other value: go to FAULT; bad_code=code.
- TRACK:
  - code==prev: hold; no pulse.
  - code==next(prev): advance; index updated; step=1; prev=code.
  - If prev==8 and code==1: additionally lap=1 and laps+1.
  - code=0: go to IDLE (upstream was reset); valid=0; index=0; laps retained.
  - Anything else (multi-hot, skipped step, backwards step): go to FAULT; bad_code=code; valid=0.
- FAULT:
  - fault=1 held; code ignored; step=lap=0.
  - clear=1: go to IDLE; fault=0, bad_code=0, prev=0; laps retained.
- Priority: reset > clear > code evaluation.
- clear outside FAULT has no effect.
- laps clears only on reset. Overflow behaviour is set by the Configuration macro.
- Index mapping is a function of the accepted code only. index holds its last value except when returning to IDLE, where it is set to 0.

## Timing
- All outputs are registered, with a single clock domain.
- code is sampled at rising edge k. The resulting state and outputs are visible after edge k; step/lap are high for exactly the cycle following edge k.
- Relative to the ring counter changing at edge n, step asserts after edge n+1 (one-cycle latency).
- step and lap are never high for two consecutive cycles unless code legally advances on consecutive edges. Back-to-back advances give back-to-back pulses.
- Fault detection latency is 1 cycle. fault stays high from the cycle after the bad sample until the cycle after clear is sampled.
- Reset asserted mid-lap returns to IDLE on the next edge regardless of code. The following samples are then evaluated from IDLE.

## Configuration
- LAP_SATURATE_EN:
  - Defined: laps saturates at 2^LAP_W−1. lap still pulses on every lap.
  - Undefined: laps wraps to 0 after 2^LAP_W−1.

## Test plan
- Reset, then code 0,1,2,4,8,1 one per cycle:
  - index 0,1,2,3,0.
  - step pulses on each of the 5 nonzero samples.
  - lap once after the final 1; laps=1; fault=0.
- Hold code=4 for 5 cycles mid-sequence: index stays 2; step=0 throughout; valid=1.
- From TRACK at prev=2, drive code=8 (skip): next cycle fault=1, bad_code=8, valid=0. Then clear=1 → IDLE, fault=0, laps unchanged.
- From IDLE, drive code=3 (multi-hot): fault=1, bad_code=3. Pulse clear and reset together: reset wins; all outputs are at reset values.
- With LAP_W=2, run 5 full laps:
  - Without LAP_SATURATE_EN: laps goes 1,2,3,0,1.
  - With LAP_SATURATE_EN: laps goes 1,2,3,3,3.
  - lap pulses 5 times in both cases.
- In TRACK at code=8, drive code=0 then 1: valid drops after the 0, then TRACK re-enters with step=1 and index=0. No lap pulse, because the 0 broke the sequence.
